bp_me_io_cmd_arbiter: RTL and testbench

- Shares one io_cmd/io_resp port (into bp_me_cce_to_io_link_bidir) among num_req_p independent io masters, e.g. nbf loader, cfg loader and a debug master.
- Replaces the fixed-priority, mutex-only steering in the test harness.
- Round-robin arbitration on commands.
- Records the source of each issued command in an in-order tag FIFO and routes each returning response to its originator.
- Bounds the number of in-flight commands.

---
 rtl/bp_me_io_cmd_arbiter.sv | 101 ++++++++++
 tb/tb_bp_me_io_cmd_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter sharing one io_cmd/io_resp port among num_req_p masters.
// Issued command sources are kept in an in-order tag FIFO that steers responses back.
module bp_me_io_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  localparam int lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int lg_out_lp        = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [lg_out_lp-1:0]             outstanding_o,
  output logic                             err_o
);
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  logic [lg_req_lp-1:0] rr_r, grant, head;
  logic [lg_req_lp-1:0] tag_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0]  rd_ptr_r, wr_ptr_r;
  logic [lg_out_lp-1:0] count_r;
  logic                 err_r, any_v, full, empty, enq, deq;

  // Full/empty come from the registered count only, so no resp-ready -> cmd-valid path exists.
  assign full  = (count_r == lg_out_lp'(max_outstanding_p));
  assign empty = (count_r == '0);
  assign any_v = |req_cmd_v_i;

  // Walk from farthest to nearest so the first valid after rr_r is the one kept.
  always_comb begin
    grant = '0;
    for (int i = num_req_p; i >= 1; i--) begin
      if (req_cmd_v_i[(int'(rr_r) + i) % num_req_p])
        grant = lg_req_lp'((int'(rr_r) + i) % num_req_p);
    end
  end

  assign io_cmd_o   = any_v ? req_cmd_i[grant*msg_width_p +: msg_width_p] : '0;
  assign io_cmd_v_o = ~reset_i & io_cmd_ready_i & any_v & ~full;
  assign enq        = io_cmd_v_o;

  assign head           = tag_mem[rd_ptr_r];
  assign req_resp_o     = io_resp_i;
  assign deq            = io_resp_v_i & ~empty & req_resp_ready_i[head];
  // Orphans (response with nothing in flight) are swallowed rather than stalling the link.
  assign io_resp_yumi_o = ~reset_i & io_resp_v_i & (empty | req_resp_ready_i[head]);

  always_comb begin
    req_cmd_yumi_o        = '0;
    req_resp_v_o          = '0;
    req_cmd_yumi_o[grant] = enq;
    req_resp_v_o[head]    = ~reset_i & ~empty & io_resp_v_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_r     <= lg_req_lp'(num_req_p - 1);
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
      for (int i = 0; i < max_outstanding_p; i++) tag_mem[i] <= '0;
    end else begin
      err_r <= io_resp_v_i & empty;
      if (enq) begin
        rr_r              <= grant;
        tag_mem[wr_ptr_r] <= grant;
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      end
      if (deq)
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      if (enq & ~deq)      count_r <= count_r + 1'b1;
      else if (deq & ~enq) count_r <= count_r - 1'b1;
    end
  end

  assign outstanding_o = count_r;
  assign err_o         = err_r;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(req_cmd_yumi_o));
      assert ($onehot0(req_resp_v_o));
      assert (!(enq && full));
      assert (!(deq && empty));
    end
  end
`endif
endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Bench for bp_me_io_cmd_arbiter: directed scenarios plus random traffic against a
// queue-based model (last winner + FIFO of owner ids + pending orphan flag).
module tb_bp_me_io_cmd_arbiter;
  localparam int N    = 2;
  localparam int W    = 32;
  localparam int MAXO = 4;
  localparam int LGO  = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             reset_i;
  logic [N*W-1:0]   req_cmd_i;
  logic [N-1:0]     req_cmd_v_i, req_cmd_yumi_o, req_resp_v_o, req_resp_ready_i;
  logic [W-1:0]     req_resp_o, io_cmd_o, io_resp_i;
  logic             io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o, err_o;
  logic [LGO-1:0]   outstanding_o;

  always #5 clk = ~clk;

  bp_me_io_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(MAXO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_ready_i(req_resp_ready_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int last_win;
  int owners[$];
  bit err_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge; outputs settle by the #1.
  task automatic drv(input logic [N-1:0] rv, input bit cr, input bit rsv, input logic [N-1:0] rdy);
    req_cmd_v_i = rv; io_cmd_ready_i = cr; io_resp_v_i = rsv; req_resp_ready_i = rdy;
    for (int k = 0; k < N; k++) req_cmd_i[k*W +: W] = $urandom;
    io_resp_i = $urandom;
    #1;
  endtask

  // Compare every output to the model, then advance the model across the clock edge.
  task automatic step();
    int g; bit anyv, cv, ryumi;
    logic [N-1:0] one, ey, erv;
    one = 1;
    if (reset_i) begin
      chk("rst_cmd_yumi", req_cmd_yumi_o, 0);
      chk("rst_io_cmd_v", io_cmd_v_o, 0);
      chk("rst_resp_v", req_resp_v_o, 0);
      chk("rst_resp_yumi", io_resp_yumi_o, 0);
      @(posedge clk);
      last_win = N - 1; owners.delete(); err_exp = 0;
      @(negedge clk);
      return;
    end
    anyv = 0; g = 0;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last_win + i) % N;
      if (!anyv && req_cmd_v_i[k]) begin anyv = 1; g = k; end
    end
    cv = io_cmd_ready_i && anyv && (owners.size() < MAXO);
    ey = cv ? (one << g) : '0;
    erv = (io_resp_v_i && owners.size() > 0) ? (one << owners[0]) : '0;
    ryumi = io_resp_v_i && (owners.size() == 0 || req_resp_ready_i[owners[0]]);
    chk("io_cmd_v", io_cmd_v_o, cv);
    chk("cmd_yumi", req_cmd_yumi_o, ey);
    chk("io_cmd", io_cmd_o, anyv ? req_cmd_i[g*W +: W] : '0);
    chk("outstanding", outstanding_o, owners.size());
    chk("err", err_o, err_exp);
    chk("resp_data", req_resp_o, io_resp_i);
    chk("resp_v", req_resp_v_o, erv);
    chk("resp_yumi", io_resp_yumi_o, ryumi);
    err_exp = io_resp_v_i && owners.size() == 0;
    if (io_resp_v_i && owners.size() > 0 && req_resp_ready_i[owners[0]]) void'(owners.pop_front());
    if (cv) begin owners.push_back(g); last_win = g; end
    @(negedge clk);
  endtask

  initial begin
    last_win = N - 1; err_exp = 0;
    @(negedge clk);
    reset_i = 1;
    drv(2'b11, 1, 1, 2'b11); step();
    drv(2'b11, 1, 1, 2'b11); step();
    reset_i = 0;

    // Alternating grants, each response one cycle behind its command.
    for (int c = 0; c < 5; c++) begin
      drv(c < 4 ? 2'b11 : 2'b00, 1, c > 0, 2'b11);
      if (c == 0) begin
        chk("lit_reset_out", outstanding_o, 0);
        chk("lit_reset_err", err_o, 0);
      end
      if (c < 4) chk("lit_t1_grant", req_cmd_yumi_o, (c % 2) ? 2'b10 : 2'b01);
      if (c > 0) begin
        chk("lit_t1_resp_v", req_resp_v_o, ((c - 1) % 2) ? 2'b10 : 2'b01);
        chk("lit_t1_out", outstanding_o, 1);
      end
      step();
    end

    // Fill to the limit from master 1, then show the one-cycle bubble.
    for (int c = 0; c < 4; c++) begin
      drv(2'b10, 1, 0, 2'b11);
      chk("lit_t2_fill", io_cmd_v_o, 1);
      step();
    end
    drv(2'b10, 1, 0, 2'b11);
    chk("lit_t2_full_out", outstanding_o, 4);
    chk("lit_t2_full_v", io_cmd_v_o, 0);
    step();
    drv(2'b10, 1, 1, 2'b11);
    chk("lit_t2_same_cycle_v", io_cmd_v_o, 0);
    chk("lit_t2_same_cycle_yumi", io_resp_yumi_o, 1);
    step();
    drv(2'b10, 1, 0, 2'b11);
    chk("lit_t2_reissue", io_cmd_v_o, 1);
    step();
    for (int c = 0; c < 4; c++) begin drv(2'b00, 1, 1, 2'b11); step(); end

    // Head-of-line stall on master 0, then in-order delivery 0,1,0.
    drv(2'b01, 1, 0, 2'b11); step();
    drv(2'b10, 1, 0, 2'b11); step();
    drv(2'b01, 1, 0, 2'b11); step();
    for (int c = 0; c < 2; c++) begin
      drv(2'b00, 1, 1, 2'b10);
      chk("lit_t3_out", outstanding_o, 3);
      chk("lit_t3_stall_yumi", io_resp_yumi_o, 0);
      chk("lit_t3_stall_v", req_resp_v_o, 2'b01);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drv(2'b00, 1, 1, 2'b11);
      chk("lit_t3_order", req_resp_v_o, (c == 1) ? 2'b10 : 2'b01);
      step();
    end

    // Orphan response.
    drv(2'b00, 1, 1, 2'b11);
    chk("lit_t4_yumi", io_resp_yumi_o, 1);
    chk("lit_t4_resp_v", req_resp_v_o, 0);
    step();
    drv(2'b00, 1, 0, 2'b11);
    chk("lit_t4_err", err_o, 1);
    chk("lit_t4_out", outstanding_o, 0);
    step();
    drv(2'b00, 1, 0, 2'b11);
    chk("lit_t4_err_clear", err_o, 0);
    step();

    // Downstream not ready: pointer must hold.
    drv(2'b01, 1, 0, 2'b11); step();
    for (int c = 0; c < 3; c++) begin
      drv(2'b11, 0, 0, 2'b11);
      chk("lit_t5_v", io_cmd_v_o, 0);
      chk("lit_t5_yumi", req_cmd_yumi_o, 0);
      step();
    end
    drv(2'b11, 1, 0, 2'b11);
    chk("lit_t5_grant", req_cmd_yumi_o, 2'b10);
    step();
    for (int c = 0; c < 2; c++) begin drv(2'b00, 1, 1, 2'b11); step(); end

    // Reset with traffic in flight; the late response becomes an orphan.
    for (int c = 0; c < 3; c++) begin drv(2'b11, 1, 0, 2'b11); step(); end
    drv(2'b00, 1, 0, 2'b11);
    chk("lit_t6_pre_out", outstanding_o, 3);
    step();
    reset_i = 1;
    drv(2'b11, 1, 0, 2'b11); step();
    reset_i = 0;
    drv(2'b00, 1, 1, 2'b11);
    chk("lit_t6_post_out", outstanding_o, 0);
    chk("lit_t6_late_yumi", io_resp_yumi_o, 1);
    chk("lit_t6_late_v", req_resp_v_o, 0);
    step();
    drv(2'b11, 1, 0, 2'b11);
    chk("lit_t6_err", err_o, 1);
    chk("lit_t6_grant", req_cmd_yumi_o, 2'b01);
    step();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      reset_i = ($urandom_range(0, 499) == 0);
      drv(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
          {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
      step();
    end
    reset_i = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
